xlat_table_init: RTL and testbench
==================================

# xlat_table_init

Synchronous sequencer that initialises the MegaMapper translation table SRAM without CPU involvement. On a start pulse it requests the Z80 bus (BUSREQ/BUSACK), walks every table entry writing either an identity mapping or a constant fill value, then releases the bus and reports done or error. It sits beside the mapper glue logic and owns the table SRAM's address, data and strobe lines only while it holds the bus.

## Interface
Parameters:
- ADDR_W, 9, table address width; DEPTH = 2**ADDR_W entries (direction bit plus 8 page bits).
- WE_CYCLES, 2, clocks tab_we_n is held low per write (legal range 1..15).
- ACK_TIMEOUT, 255, clocks to wait for busack_n before aborting (legal range 1..65535).

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-clock request to begin initialisation.
- fill_mode  in  1  0 = identity (entry = addr[7:0]), 1 = constant.
- fill_value  in  8  constant used when fill_mode = 1.
- busreq_n  out  1  Z80 bus request, active low.
- busack_n  in  1  Z80 bus acknowledge, active low; already synchronised to clk.
- tab_addr  out  ADDR_W  table SRAM address.
- tab_dout  out  8  write data.
- tab_doe  out  1  drive enable for tab_dout onto the shared data bus.
- tab_we_n  out  1  SRAM write strobe.
- tab_oe_n  out  1  SRAM output enable; used only for verify reads.
- tab_din  in  8  SRAM read data; used only for verify reads.
- busy  out  1  high from the accepted start until done or error is set.
- done  out  1  sticky success flag; cleared by the next accepted start.
- error  out  1  sticky failure flag; cleared by the next accepted start.

## Operation
- Reset values: busreq_n=1, tab_we_n=1, tab_oe_n=1, tab_doe=0, tab_addr=0, tab_dout=0, busy=0, done=0, error=0; FSM in IDLE.
- IDLE: start=1 latches fill_mode and fill_value, clears done and error, sets busy, clears the address counter, and moves to REQ.
- REQ: busreq_n=0 and the timeout counter runs. busack_n=0 moves to SETUP. If the counter reaches ACK_TIMEOUT first: set error, go to RELEASE.
- SETUP (1 clk): tab_addr = counter, tab_dout = pattern, tab_doe=1.
- WRITE (WE_CYCLES clk): tab_we_n=0; address and data stay stable.
- HOLD (1 clk): tab_we_n=1, tab_doe still 1. If counter = DEPTH-1, go to VSETUP (VERIFY_EN) or RELEASE. Otherwise increment the counter and return to SETUP.
- RELEASE (1 clk): tab_doe=0, busreq_n=1, busy=0. Set done unless error is set. Return to IDLE.
- Abort: if busack_n=1 in any of SETUP, WRITE, HOLD or a verify state, set error and go to RELEASE immediately; tab_we_n returns to 1 that same clock.
- start while busy is ignored.
- Counter width is ADDR_W; it is never allowed to wrap past DEPTH-1.

## Timing
- From the accepted start, busreq_n falls on the next rising edge.
- Each entry costs WE_CYCLES+2 clocks. Total time after busack = DEPTH*(WE_CYCLES+2) clocks, plus 1 for RELEASE. With defaults: 512*4+1 = 2049 clocks.
- Address and data are valid one full clock before tab_we_n falls and one full clock after it rises.
- done/error are set on the same edge that busy falls.
- Asynchronous reset mid-operation forces every output to its reset value immediately, which releases the bus.
- Simultaneous start and abort are impossible; start is only sampled in IDLE.

## Configuration
- Macro XLAT_VERIFY_EN.
- When defined, a read-back pass follows the write pass:
  - The counter restarts at 0.
  - VSETUP (1 clk): tab_oe_n=0, tab_doe=0.
  - VREAD (1 clk): compare tab_din with the expected pattern; any mismatch sets error.
  - All DEPTH entries are checked (no early exit), then RELEASE.
  - Adds DEPTH*2 clocks.
- When undefined: tab_oe_n is tied to 1, tab_din is unused, and the FSM goes from the last HOLD straight to RELEASE.

## Test plan
- Identity fill with defaults, busack_n=0 two clocks after busreq_n falls -> 512 writes, entry 0x1A5 = 0xA5, done=1 and busreq_n=1 after 2049 clocks (without verify).
- fill_mode=1, fill_value=0x3C -> every write carries 0x3C, tab_we_n low exactly 2 clocks per entry.
- busack_n held high -> after 255 clocks: error=1, done=0, busreq_n=1, no tab_we_n pulse.
- busack_n raised during entry 17's WRITE -> tab_we_n=1 on the next edge, error=1, tab_doe=0, FSM in IDLE.
- reset_n pulsed low mid-write -> all outputs at reset values asynchronously; a fresh start afterwards completes normally.
- XLAT_VERIFY_EN with the model corrupting entry 0x040 -> all 512 entries read, error=1, done=0.

Source files
------------

// File: rtl/xlat_table_init.sv
// xlat_table_init: fills the mapper translation table SRAM while holding the Z80 bus.
// Optional read-back pass is enabled by defining XLAT_VERIFY_EN.
module xlat_table_init #(
  parameter int ADDR_W      = 9,
  parameter int WE_CYCLES   = 2,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              fill_mode,
  input  logic [7:0]        fill_value,
  output logic              busreq_n,
  input  logic              busack_n,
  output logic [ADDR_W-1:0] tab_addr,
  output logic [7:0]        tab_dout,
  output logic              tab_doe,
  output logic              tab_we_n,
  output logic              tab_oe_n,
  input  logic [7:0]        tab_din,
  output logic              busy,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_SETUP, S_WRITE,
    S_HOLD, S_VSETUP, S_VREAD, S_REL
  } state_e;

  localparam logic [ADDR_W-1:0] LAST     = '1;
  localparam logic [3:0]        WE_LAST  = 4'(WE_CYCLES - 1);
  localparam logic [15:0]       TMO_LAST = 16'(ACK_TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [15:0]       tmo_q, tmo_d;
  logic [3:0]        wcnt_q, wcnt_d;
  logic              mode_q, mode_d;
  logic [7:0]        fill_q, fill_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [7:0]        pat;
  logic              bus_held;

  assign pat = mode_q ? fill_q : cnt_q[7:0];
  assign bus_held = state_q inside
    {S_SETUP, S_WRITE, S_HOLD, S_VSETUP, S_VREAD};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      tmo_q   <= '0;
      wcnt_q  <= '0;
      mode_q  <= 1'b0;
      fill_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      wcnt_q  <= wcnt_d;
      mode_q  <= mode_d;
      fill_q  <= fill_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    wcnt_d  = wcnt_q;
    mode_d  = mode_q;
    fill_d  = fill_q;
    done_d  = done_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: if (start) begin
        mode_d  = fill_mode;
        fill_d  = fill_value;
        done_d  = 1'b0;
        err_d   = 1'b0;
        cnt_d   = '0;
        tmo_d   = '0;
        state_d = S_REQ;
      end
      S_REQ: begin
        if (!busack_n) begin
          state_d = S_SETUP;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = S_REL;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      S_SETUP: begin
        wcnt_d  = '0;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        if (wcnt_q == WE_LAST) state_d = S_HOLD;
        else wcnt_d = wcnt_q + 4'd1;
      end
      S_HOLD: begin
        if (cnt_q == LAST) begin
`ifdef XLAT_VERIFY_EN
          cnt_d   = '0;
          state_d = S_VSETUP;
`else
          state_d = S_REL;
`endif
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = S_SETUP;
        end
      end
`ifdef XLAT_VERIFY_EN
      S_VSETUP: state_d = S_VREAD;
      S_VREAD: begin
        if (tab_din != pat) err_d = 1'b1;
        if (cnt_q == LAST) begin
          state_d = S_REL;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = S_VSETUP;
        end
      end
`endif
      S_REL: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Losing the bus mid-pass overrides any normal transition.
    if (bus_held && busack_n) begin
      err_d   = 1'b1;
      state_d = S_REL;
    end
    if (state_d == S_REL && state_q != S_REL) done_d = !err_d;
  end

  assign busy     = !(state_q == S_IDLE || state_q == S_REL);
  assign busreq_n = !busy;
  assign tab_addr = cnt_q;
  assign tab_doe  = state_q inside {S_SETUP, S_WRITE, S_HOLD};
  assign tab_dout = tab_doe ? pat : 8'h00;
  assign tab_we_n = state_q != S_WRITE;
  assign done     = done_q;
  assign error    = err_q;

`ifdef XLAT_VERIFY_EN
  assign tab_oe_n = !(state_q == S_VSETUP || state_q == S_VREAD);
`else
  logic unused_din;
  assign unused_din = ^tab_din;
  assign tab_oe_n   = 1'b1;
`endif

endmodule

// File: tb/tb_xlat_table_init.sv
// tb_xlat_table_init: directed bench for xlat_table_init with an SRAM model.
// Define XLAT_VERIFY_EN to exercise the read-back pass.
module tb_xlat_table_init;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic       fill_mode;
  logic [7:0] fill_value;
  logic       busreq_n;
  logic       busack_n;
  logic [8:0] tab_addr;
  logic [7:0] tab_dout;
  logic       tab_doe;
  logic       tab_we_n;
  logic       tab_oe_n;
  logic [7:0] tab_din;
  logic       busy;
  logic       done;
  logic       error;

  int errors = 0;
  int checks = 0;

  logic [7:0] mem [512];
  logic       corrupt = 1'b0;
  logic       exp_mode = 1'b0;
  logic [7:0] exp_val = 8'h00;

  int n_writes = 0;
  int bad_pulse = 0;
  int bad_data = 0;
  int doe_cyc = 0;
  int oe_cyc = 0;
  int run = 0;

`ifdef XLAT_VERIFY_EN
  localparam int EXP_OE = 1024;
`else
  localparam int EXP_OE = 0;
`endif

  xlat_table_init dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .fill_mode  (fill_mode),
    .fill_value (fill_value),
    .busreq_n   (busreq_n),
    .busack_n   (busack_n),
    .tab_addr   (tab_addr),
    .tab_dout   (tab_dout),
    .tab_doe    (tab_doe),
    .tab_we_n   (tab_we_n),
    .tab_oe_n   (tab_oe_n),
    .tab_din    (tab_din),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  assign tab_din = (corrupt && tab_addr == 9'h040) ?
                   ~mem[tab_addr] : mem[tab_addr];

  // SRAM model and strobe monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (!tab_we_n) begin
      mem[tab_addr] = tab_dout;
      if (run == 0) n_writes++;
      run++;
      if (!tab_doe ||
          tab_dout !== (exp_mode ? exp_val : tab_addr[7:0]))
        bad_data++;
    end else begin
      if (run != 0 && run != 2) bad_pulse++;
      run = 0;
    end
    if (tab_doe) doe_cyc++;
    if (!tab_oe_n) oe_cyc++;
  end

  task automatic do_start(input logic m, input logic [7:0] v);
    @(negedge clk);
    fill_mode  = m;
    fill_value = v;
    start      = 1'b1;
    exp_mode   = m;
    exp_val    = v;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int limit, output int cyc);
    cyc = 0;
    while (busy && cyc < limit) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    reset_n    = 1'b0;
    start      = 1'b0;
    fill_mode  = 1'b0;
    fill_value = 8'h00;
    busack_n   = 1'b1;
    #12;
    checks++;
    if ({busreq_n, tab_we_n, tab_oe_n, tab_doe, tab_addr, tab_dout,
         busy, done, error} !== {4'b1110, 9'h0, 8'h0, 3'b000}) begin
      errors++;
      $display("FAIL reset_outs: got %b %b %b %b %h %h %b %b %b",
               busreq_n, tab_we_n, tab_oe_n, tab_doe, tab_addr,
               tab_dout, busy, done, error);
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || busreq_n !== 1'b1) begin
      errors++;
      $display("FAIL reset_idle: busy=%b busreq_n=%b want 0 1",
               busy, busreq_n);
    end
  endtask

  task automatic test_identity;
    int w0, p0, d0, e0, o0, cyc, bad;
    w0 = n_writes; p0 = bad_pulse; d0 = doe_cyc;
    e0 = bad_data; o0 = oe_cyc;
    do_start(1'b0, 8'h00);
    checks++;
    if (busreq_n !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL id_req: busreq_n=%b busy=%b want 0 1",
               busreq_n, busy);
    end
    repeat (2) @(negedge clk);
    busack_n = 1'b0;
    wait_idle(5000, cyc);
    checks++;
    if (cyc >= 5000) begin
      errors++;
      $display("FAIL id_timeout: busy still %b after %0d", busy, cyc);
    end
    checks++;
    if (done !== 1'b1 || error !== 1'b0 || busreq_n !== 1'b1 ||
        tab_doe !== 1'b0) begin
      errors++;
      $display("FAIL id_flags: done=%b err=%b busreq_n=%b doe=%b want 1 0 1 0",
               done, error, busreq_n, tab_doe);
    end
    busack_n = 1'b1;
    checks++;
    if (n_writes - w0 != 512) begin
      errors++;
      $display("FAIL id_writes: got %0d want 512", n_writes - w0);
    end
    checks++;
    if (doe_cyc - d0 != 2048) begin
      errors++;
      $display("FAIL id_doe_cycles: got %0d want 2048", doe_cyc - d0);
    end
    checks++;
    if (mem[9'h1A5] !== 8'hA5) begin
      errors++;
      $display("FAIL id_entry_1a5: got %h want a5", mem[9'h1A5]);
    end
    bad = 0;
    for (int i = 0; i < 512; i++)
      if (mem[i] !== 8'(i)) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL id_table: %0d wrong entries want 0", bad);
    end
    checks++;
    if (bad_pulse - p0 != 0 || bad_data - e0 != 0) begin
      errors++;
      $display("FAIL id_strobes: bad_pulse=%0d bad_data=%0d want 0 0",
               bad_pulse - p0, bad_data - e0);
    end
    checks++;
    if (oe_cyc - o0 != EXP_OE) begin
      errors++;
      $display("FAIL id_oe_cycles: got %0d want %0d", oe_cyc - o0, EXP_OE);
    end
    @(negedge clk);
  endtask

  task automatic test_const;
    int w0, p0, e0, cyc, bad;
    w0 = n_writes; p0 = bad_pulse; e0 = bad_data;
    do_start(1'b1, 8'h3C);
    repeat (2) @(negedge clk);
    busack_n = 1'b0;
    repeat (40) @(negedge clk);
    fill_mode  = 1'b0;
    fill_value = 8'h99;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle(5000, cyc);
    checks++;
    if (cyc >= 5000) begin
      errors++;
      $display("FAIL cf_timeout: busy still %b after %0d", busy, cyc);
    end
    busack_n = 1'b1;
    checks++;
    if (done !== 1'b1 || error !== 1'b0) begin
      errors++;
      $display("FAIL cf_flags: done=%b err=%b want 1 0", done, error);
    end
    checks++;
    if (n_writes - w0 != 512 || bad_pulse - p0 != 0) begin
      errors++;
      $display("FAIL cf_pulses: writes=%0d bad_pulse=%0d want 512 0",
               n_writes - w0, bad_pulse - p0);
    end
    checks++;
    if (bad_data - e0 != 0) begin
      errors++;
      $display("FAIL cf_data: %0d bad write beats want 0", bad_data - e0);
    end
    bad = 0;
    for (int i = 0; i < 512; i++)
      if (mem[i] !== 8'h3C) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL cf_table: %0d wrong entries want 0", bad);
    end
    @(negedge clk);
  endtask

  task automatic test_ack_timeout;
    int w0, cyc;
    w0 = n_writes;
    do_start(1'b0, 8'h00);
    wait_idle(1000, cyc);
    checks++;
    if (cyc != 255) begin
      errors++;
      $display("FAIL to_cycles: got %0d want 255", cyc);
    end
    checks++;
    if (error !== 1'b1 || done !== 1'b0 || busreq_n !== 1'b1) begin
      errors++;
      $display("FAIL to_flags: err=%b done=%b busreq_n=%b want 1 0 1",
               error, done, busreq_n);
    end
    checks++;
    if (n_writes - w0 != 0) begin
      errors++;
      $display("FAIL to_writes: got %0d want 0", n_writes - w0);
    end
    @(negedge clk);
  endtask

  task automatic test_abort;
    int w0, cyc;
    w0 = n_writes;
    do_start(1'b0, 8'h00);
    repeat (2) @(negedge clk);
    busack_n = 1'b0;
    cyc = 0;
    while (!(tab_addr == 9'd17 && !tab_we_n) && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc >= 500) begin
      errors++;
      $display("FAIL ab_reach17: addr=%h we_n=%b", tab_addr, tab_we_n);
    end
    busack_n = 1'b1;
    @(negedge clk);
    checks++;
    if (tab_we_n !== 1'b1 || tab_doe !== 1'b0 || error !== 1'b1 ||
        done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ab_flags: we_n=%b doe=%b err=%b done=%b busy=%b want 1 0 1 0 0",
               tab_we_n, tab_doe, error, done, busy);
    end
    @(negedge clk);
    checks++;
    if (busreq_n !== 1'b1 || tab_addr !== 9'h000) begin
      errors++;
      $display("FAIL ab_idle: busreq_n=%b addr=%h want 1 000",
               busreq_n, tab_addr);
    end
    checks++;
    if (n_writes - w0 != 18) begin
      errors++;
      $display("FAIL ab_writes: got %0d want 18", n_writes - w0);
    end
  endtask

  task automatic test_reset_mid;
    int w0, cyc;
    do_start(1'b0, 8'h00);
    repeat (2) @(negedge clk);
    busack_n = 1'b0;
    cyc = 0;
    while (!(tab_addr == 9'd100 && !tab_we_n) && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({busreq_n, tab_we_n, tab_oe_n, tab_doe, tab_addr, tab_dout,
         busy, done, error} !== {4'b1110, 9'h0, 8'h0, 3'b000}) begin
      errors++;
      $display("FAIL rm_async: got %b %b %b %b %h %h %b %b %b",
               busreq_n, tab_we_n, tab_oe_n, tab_doe, tab_addr,
               tab_dout, busy, done, error);
    end
    busack_n = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    w0 = n_writes;
    do_start(1'b0, 8'h00);
    repeat (2) @(negedge clk);
    busack_n = 1'b0;
    wait_idle(5000, cyc);
    busack_n = 1'b1;
    checks++;
    if (cyc >= 5000 || done !== 1'b1 || error !== 1'b0 ||
        n_writes - w0 != 512) begin
      errors++;
      $display("FAIL rm_rerun: cyc=%0d done=%b err=%b writes=%0d want done 1 err 0 writes 512",
               cyc, done, error, n_writes - w0);
    end
    @(negedge clk);
  endtask

`ifdef XLAT_VERIFY_EN
  task automatic test_verify;
    int o0, cyc;
    o0 = oe_cyc;
    do_start(1'b0, 8'h00);
    repeat (2) @(negedge clk);
    busack_n = 1'b0;
    while (tab_oe_n && busy) @(negedge clk);
    corrupt = 1'b1;
    wait_idle(5000, cyc);
    busack_n = 1'b1;
    corrupt  = 1'b0;
    checks++;
    if (oe_cyc - o0 != 1024) begin
      errors++;
      $display("FAIL vf_reads: oe cycles %0d want 1024", oe_cyc - o0);
    end
    checks++;
    if (error !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL vf_flags: err=%b done=%b want 1 0", error, done);
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset;
    test_identity;
    test_const;
    test_ack_timeout;
    test_abort;
    test_reset_mid;
`ifdef XLAT_VERIFY_EN
    test_verify;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
